// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional skid entry, flush,
// exception merge, Tnew countdown presentation and a saturating stall counter.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 128,
  parameter int ADDR_W    = 5,
  parameter int T_W       = 4,
  parameter int TUSE_IDLE = 4,
  parameter int EXC_W     = 5,
  parameter int SKID      = 1,
  parameter int DEC_TNEW  = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [ADDR_W-1:0]    in_dst_addr,
  input  logic [T_W-1:0]       in_tnew,
  input  logic [T_W-1:0]       in_rs_tuse,
  input  logic [T_W-1:0]       in_rt_tuse,
  input  logic                 in_exc,
  input  logic [EXC_W-1:0]     in_exc_code,
  input  logic                 local_exc,
  input  logic [EXC_W-1:0]     local_exc_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [ADDR_W-1:0]    out_dst_addr,
  output logic [T_W-1:0]       out_tnew,
  output logic [T_W-1:0]       out_rs_tuse,
  output logic [T_W-1:0]       out_rt_tuse,
  output logic                 out_exc,
  output logic [EXC_W-1:0]     out_exc_code,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ADDR_W-1:0]    dst_addr;
    logic [T_W-1:0]       tnew;
    logic [T_W-1:0]       rs_tuse;
    logic [T_W-1:0]       rt_tuse;
    logic                 exc;
    logic [EXC_W-1:0]     exc_code;
  } entry_t;

  entry_t           main_q, main_d, skid_q, skid_d, in_entry;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             accept, emit;

  // Upstream exception wins over one raised by the producing stage.
  always_comb begin
    in_entry.payload  = in_payload;
    in_entry.dst_addr = in_dst_addr;
    in_entry.tnew     = in_tnew;
    in_entry.rs_tuse  = in_rs_tuse;
    in_entry.rt_tuse  = in_rt_tuse;
    in_entry.exc      = in_exc | local_exc;
    if (in_exc)         in_entry.exc_code = in_exc_code;
    else if (local_exc) in_entry.exc_code = local_exc_code;
    else                in_entry.exc_code = '0;
  end

  always_comb begin
    out_valid = main_valid_q & ~flush;
    if (SKID != 0) in_ready = ~flush & ~skid_valid_q;
    else           in_ready = ~flush & (~main_valid_q | out_ready);
    accept = in_valid & in_ready;
    emit   = out_valid & out_ready;
  end

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (emit) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    // Arrivals fill main first; skid only takes one behind an occupied main.
    if (accept) begin
      if (!main_valid_d) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_comb begin
    if (!out_valid || out_ready) stall_cnt_d = '0;
    else if (stall_cnt_q != '1)  stall_cnt_d = stall_cnt_q + 1'b1;
    else                         stall_cnt_d = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  always_comb begin
    out_payload  = '0;
    out_dst_addr = '0;
    out_tnew     = '0;
    out_rs_tuse  = T_W'(TUSE_IDLE);
    out_rt_tuse  = T_W'(TUSE_IDLE);
    out_exc      = 1'b0;
    out_exc_code = '0;
    if (out_valid) begin
      out_payload  = main_q.payload;
      out_dst_addr = main_q.dst_addr;
      if (DEC_TNEW != 0 && main_q.tnew != '0) out_tnew = main_q.tnew - 1'b1;
      else if (DEC_TNEW != 0)                 out_tnew = '0;
      else                                    out_tnew = main_q.tnew;
      out_rs_tuse  = main_q.rs_tuse;
      out_rt_tuse  = main_q.rt_tuse;
      out_exc      = main_q.exc;
      out_exc_code = main_q.exc_code;
    end
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, each checked every
// cycle against a queue model of the stage, plus directed literal expectations.
module tb_pipe_stage_reg;
  localparam int PW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, flush;
  logic [1:0]           in_valid, in_ready, in_exc, local_exc, out_valid, out_ready, out_exc;
  logic [1:0][PW-1:0]   in_payload, out_payload;
  logic [1:0][4:0]      in_dst, out_dst, in_exc_code, local_exc_code, out_exc_code;
  logic [1:0][3:0]      in_tnew, in_rs, in_rt, out_tnew, out_rs, out_rt;
  logic [1:0][7:0]      stall_cnt;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipe_stage_reg #(.SKID(g)) u_dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_payload(in_payload[g]),
      .in_dst_addr(in_dst[g]), .in_tnew(in_tnew[g]), .in_rs_tuse(in_rs[g]),
      .in_rt_tuse(in_rt[g]), .in_exc(in_exc[g]), .in_exc_code(in_exc_code[g]),
      .local_exc(local_exc[g]), .local_exc_code(local_exc_code[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_payload(out_payload[g]),
      .out_dst_addr(out_dst[g]), .out_tnew(out_tnew[g]), .out_rs_tuse(out_rs[g]),
      .out_rt_tuse(out_rt[g]), .out_exc(out_exc[g]), .out_exc_code(out_exc_code[g]),
      .stall_cnt(stall_cnt[g])
    );
  end

  typedef struct packed {
    logic [PW-1:0] pl;
    logic [4:0]    dst;
    logic [3:0]    tn, rs, rt;
    logic          exc;
    logic [4:0]    code;
  } ent_t;

  ent_t me [2][2];
  int   mcnt [2];
  int   msc [2];
  bit   acc_last [2];
  int   emitted [2];
  bit   started;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int d, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h want=%0h", nm, d, act, exp);
    end
  endtask

  // Model: the stage is a FIFO of depth 1 (SKID=0) or 2 (SKID=1).
  function automatic bit m_rdy(input int d);
    if (flush) return 1'b0;
    if (d == 1) return mcnt[d] < 2;
    return (mcnt[d] == 0) || out_ready[d];
  endfunction

  function automatic ent_t present(input int d);
    ent_t e;
    if (mcnt[d] > 0 && !flush) begin
      e = me[d][0];
      if (e.tn != 4'd0) e.tn = e.tn - 4'd1;
    end else begin
      e = '0;
      e.rs = 4'd4;
      e.rt = 4'd4;
    end
    return e;
  endfunction

  function automatic ent_t mk_entry(input int d);
    ent_t e;
    e.pl   = in_payload[d];
    e.dst  = in_dst[d];
    e.tn   = in_tnew[d];
    e.rs   = in_rs[d];
    e.rt   = in_rt[d];
    e.exc  = in_exc[d] | local_exc[d];
    e.code = in_exc[d] ? in_exc_code[d] : (local_exc[d] ? local_exc_code[d] : 5'd0);
    return e;
  endfunction

  initial begin
    started = 1'b0;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        bit rdy, ov, em, acc;
        rdy = m_rdy(d);
        ov  = (mcnt[d] > 0) && !flush;
        em  = ov && out_ready[d];
        acc = in_valid[d] && rdy;
        acc_last[d] = 1'b0;
        if (reset || flush) begin
          mcnt[d] = 0;
          msc[d]  = 0;
        end else begin
          if (ov && !out_ready[d]) msc[d] = (msc[d] == 255) ? 255 : msc[d] + 1;
          else                     msc[d] = 0;
          if (em) begin
            me[d][0] = me[d][1];
            mcnt[d]--;
          end
          if (acc) begin
            me[d][mcnt[d]] = mk_entry(d);
            mcnt[d]++;
            acc_last[d] = 1'b1;
          end
        end
      end
      if (reset) started = 1'b1;
    end
  end

  initial begin
    emitted[0] = 0;
    emitted[1] = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int d = 0; d < 2; d++) begin
          chk("in_ready", d, 160'(in_ready[d]), 160'(m_rdy(d)));
          chk("out_valid", d, 160'(out_valid[d]), 160'((mcnt[d] > 0) && !flush));
          chk("fields", d, 160'({out_payload[d], out_dst[d], out_tnew[d], out_rs[d], out_rt[d],
                                 out_exc[d], out_exc_code[d]}), 160'(present(d)));
          chk("stall_cnt", d, 160'(stall_cnt[d]), 160'(msc[d]));
          if (out_valid[d] && out_ready[d]) emitted[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int d, input bit v, input logic [PW-1:0] pl, input logic [3:0] tn,
                       input bit ie, input logic [4:0] ic, input bit le, input logic [4:0] lc);
    in_valid[d]       = v;
    in_payload[d]     = pl;
    in_dst[d]         = 5'($urandom);
    in_tnew[d]        = tn;
    in_rs[d]          = 4'($urandom);
    in_rt[d]          = 4'($urandom);
    in_exc[d]         = ie;
    in_exc_code[d]    = ic;
    local_exc[d]      = le;
    local_exc_code[d] = lc;
  endtask

  task automatic both(input bit v, input logic [PW-1:0] pl, input logic [3:0] tn,
                      input bit ie, input logic [4:0] ic, input bit le, input logic [4:0] lc);
    offer(0, v, pl, tn, ie, ic, le, lc);
    offer(1, v, pl, tn, ie, ic, le, lc);
  endtask

  int sent [2];
  int base [2];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 2'b00;
    both(1'b1, 128'h1, 4'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) tick();

    // Reset release with in_valid held high.
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, 160'(in_ready[d]), 160'(1));
      chk("rst_out_valid", d, 160'(out_valid[d]), 160'(0));
      chk("rst_rs_tuse", d, 160'(out_rs[d]), 160'(4));
      chk("rst_tnew", d, 160'(out_tnew[d]), 160'(0));
    end
    tick();
    both(1'b0, 128'h0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("first_valid", d, 160'(out_valid[d]), 160'(1));
      chk("first_tnew", d, 160'(out_tnew[d]), 160'(2));
    end
    tick();
    out_ready = 2'b11;
    tick();
    out_ready = 2'b00;

    // Skid fill: A then B with downstream stalled.
    both(1'b1, 128'hA, 4'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    both(1'b1, 128'hB, 4'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    both(1'b0, 128'h0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("skid_full_ready", 1, 160'(in_ready[1]), 160'(0));
    chk("stall_1", 1, 160'(stall_cnt[1]), 160'(1));
    tick();
    @(negedge clk);
    chk("stall_2", 1, 160'(stall_cnt[1]), 160'(2));
    tick();
    @(negedge clk);
    chk("stall_3", 1, 160'(stall_cnt[1]), 160'(3));
    tick();
    out_ready = 2'b11;
    @(negedge clk);
    chk("drain_A", 1, 160'(out_payload[1]), 160'(128'hA));
    tick();
    @(negedge clk);
    chk("drain_B", 1, 160'(out_payload[1]), 160'(128'hB));
    chk("ready_back", 1, 160'(in_ready[1]), 160'(1));
    tick();
    @(negedge clk);
    chk("drained", 1, 160'(out_valid[1]), 160'(0));

    // Exception merge, with out_ready held high.
    tick();
    both(1'b1, 128'hC, 4'd5, 1'b1, 5'd4, 1'b1, 5'd12);
    tick();
    both(1'b1, 128'hD, 4'd0, 1'b0, 5'd0, 1'b1, 5'd12);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("exc_up_code", d, 160'(out_exc_code[d]), 160'(4));
      chk("exc_up_tnew", d, 160'(out_tnew[d]), 160'(4));
    end
    tick();
    both(1'b0, 128'h0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("exc_loc_flag", d, 160'(out_exc[d]), 160'(1));
      chk("exc_loc_code", d, 160'(out_exc_code[d]), 160'(12));
      chk("tnew_sat0", d, 160'(out_tnew[d]), 160'(0));
    end
    tick();

    // Flush with both entries held and a new offer pending.
    out_ready = 2'b00;
    both(1'b1, 128'hE, 4'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    both(1'b1, 128'hF, 4'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    flush = 1'b1;
    both(1'b1, 128'h7, 4'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("flush_ready", 1, 160'(in_ready[1]), 160'(0));
    chk("flush_valid", 1, 160'(out_valid[1]), 160'(0));
    chk("flush_payload", 1, 160'(out_payload[1]), 160'(0));
    tick();
    flush = 1'b0;
    both(1'b0, 128'h0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("post_flush_valid", 1, 160'(out_valid[1]), 160'(0));
    chk("post_flush_rs", 1, 160'(out_rs[1]), 160'(4));
    chk("post_flush_stall", 1, 160'(stall_cnt[1]), 160'(0));

    // Random streaming of 10 entries per instance with toggling out_ready.
    for (int d = 0; d < 2; d++) begin
      sent[d] = 0;
      base[d] = emitted[d];
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (emitted[0] - base[0] >= 10 && emitted[1] - base[1] >= 10) break;
      tick();
      for (int d = 0; d < 2; d++) begin
        if (acc_last[d]) begin
          sent[d]++;
          in_valid[d] = 1'b0;
        end
        if (!in_valid[d] && sent[d] < 10 && $urandom_range(3) != 0)
          offer(d, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
                1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
        out_ready[d] = 1'($urandom_range(1));
      end
    end
    for (int d = 0; d < 2; d++) chk("stream_count", d, 160'(emitted[d] - base[d]), 160'(10));
    both(1'b0, 128'h0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    out_ready = 2'b11;
    tick();
    tick();

    // Stall counter saturation under a long hold.
    out_ready = 2'b00;
    both(1'b1, 128'h55, 4'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    both(1'b0, 128'h0, 4'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (300) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("stall_sat", d, 160'(stall_cnt[d]), 160'(255));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, optional skid entry, flush/bubble insertion, saturating Tnew countdown, Tuse passthrough and exception merging. It carries one instruction's payload and hazard metadata between adjacent stages (F/D, D/E, E/M, M/W). The hazard unit consumes its dst/Tnew/Tuse outputs for stall and forward decisions.

## Interface
Parameters:
- PAYLOAD_W, 128: width of opaque instruction payload (PC, immediates, control bits).
- ADDR_W, 5: register address width.
- T_W, 4: width of Tnew/Tuse fields.
- TUSE_IDLE, 4: Tuse value presented for bubbles (means "never reads").
- EXC_W, 5: exception code width.
- SKID, 1: 1 gives a two-entry buffer with registered in_ready; 0 gives a single entry.
- DEC_TNEW, 1: 1 presents Tnew decremented (saturating at 0); 0 passes it through.
- CNT_W, 8: stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all held entries (synchronous).
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  this stage accepts this cycle.
- in_payload  in  PAYLOAD_W  payload.
- in_dst_addr  in  ADDR_W  destination register.
- in_tnew  in  T_W  cycles until result available.
- in_rs_tuse, in_rt_tuse  in  T_W  cycles until rs/rt needed.
- in_exc  in  1  upstream exception flag.
- in_exc_code  in  EXC_W  upstream exception code.
- local_exc  in  1  exception raised by the producing stage.
- local_exc_code  in  EXC_W  its code.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_payload  out  PAYLOAD_W, out_dst_addr  out  ADDR_W, out_tnew  out  T_W, out_rs_tuse, out_rt_tuse  out  T_W, out_exc  out  1, out_exc_code  out  EXC_W: head-entry fields.
- stall_cnt  out  CNT_W  consecutive cycles head is valid but not accepted.

## Operation
- Accept = in_valid & in_ready; emit = out_valid & out_ready. Strict FIFO order.
- SKID=0: in_ready = !flush & (!main_valid | out_ready).
- SKID=1: in_ready = !flush & !skid_valid (registered state only, with no combinational path from out_ready). When main is full and not emitted, an accept goes to skid. When main emits, skid (if valid) moves to main in the same edge; a simultaneous accept then lands in skid. Combinational bypass around main is forbidden.
- Capture: fields stored verbatim except exception merge. If in_exc, store in_exc/in_exc_code. Else if local_exc, store 1/local_exc_code. Else store 0/0. Upstream exceptions take priority.
- Output Tnew: if DEC_TNEW, out_tnew = (stored==0) ? 0 : stored−1. Otherwise out_tnew = stored. Tnew does not change while the entry is held.
- Bubble: when out_valid=0, outputs are forced to payload 0, dst_addr 0, tnew 0, rs/rt_tuse TUSE_IDLE, exc 0, code 0, regardless of stale storage.
- Flush: while flush=1, out_valid=0 and in_ready=0, so no transfer occurs. At the edge, both entries are invalidated. Flush dominates in_valid and out_ready.
- stall_cnt: +1 per cycle with out_valid & !out_ready, saturating at 2^CNT_W−1. Cleared to 0 on emit, flush, reset or when out_valid=0.

## Timing
- Reset (sync, at the edge): main/skid invalid, stall_cnt 0. In the following cycle: out_valid 0, bubble outputs as above, in_ready 1.
- Latency: an entry accepted at edge N is presented with out_valid=1 after edge N; it is emittable in cycle N+1.
- Throughput: 1 per cycle with out_ready held 1, for either SKID value.
- SKID=1 full (both entries valid): in_ready=0 the cycle after the second accept. It returns to 1 the cycle after an emit.
- Reset asserted mid-transfer: the transfer is ignored, and reset state is reached after that edge.
- reset and flush together: behaves as reset.

## Test plan
- Reset with in_valid=1 held: after release, out_valid=0, out_rs_tuse=4, out_tnew=0, in_ready=1. The first accept (tnew=3) appears next cycle with out_tnew=2.
- SKID=1, out_ready=0, push A then B: in_ready goes 0 after B, and stall_cnt counts 1,2,3… Then out_ready=1 yields A then B in consecutive cycles, with in_ready back to 1 the cycle after A's emit.
- Exception merge: in_exc=1/code 4 with local_exc=1/code 12 stores code 4. in_exc=0 with local_exc=1/code 12 stores exc=1, code 12.
- Flush with both entries valid and in_valid=1: in_ready=0 and out_valid=0 during flush. Both entries are gone next cycle, and the outputs are bubble values.
- Streaming 10 entries with out_ready toggling pseudo-randomly (SKID=0 and SKID=1): no loss, duplication or reordering, out_tnew = max(in_tnew−1, 0), stall_cnt saturates at 255 under a 300-cycle hold.
